// File: rtl/button_event_pkg.sv
// Shared event record and default parameters for button_event_ctrl.
// BUTTON_EVENT_CTRL_TIMESTAMP_EN adds a 16-bit tick stamp to each event.
package button_event_pkg;

    localparam int N_INPUTS_DEFAULT     = 4;
    localparam int TICK_CYCLES_DEFAULT  = 16_000;
    localparam int STABLE_TICKS_DEFAULT = 10;
    localparam int FIFO_DEPTH_DEFAULT   = 4;

    // Channel field sized for the largest supported input count (16).
    localparam int CHAN_W  = 4;
    localparam int STAMP_W = 16;

    typedef struct packed {
`ifdef BUTTON_EVENT_CTRL_TIMESTAMP_EN
        logic [STAMP_W-1:0] stamp;
`endif
        logic [CHAN_W-1:0]  chan;
        logic               press;
    } evt_t;

endpackage

// File: rtl/button_event_ctrl_fifo.sv
// evt_fifo: synchronous event queue with flop-based storage.
// Head is read straight from storage flops; full/empty from a count.
module evt_fifo
    import button_event_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic aclk,
    input  logic reset,
    input  logic push,
    input  evt_t data,
    output logic full,
    input  logic pop,
    output evt_t head,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A push is still accepted when full if the head leaves this cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: debounced buttons with a queued press/release stream.
// Option BUTTON_EVENT_CTRL_TIMESTAMP_EN adds ev_time (tick count stamp).
module button_event_ctrl
    import button_event_pkg::*;
#(
    parameter int N_INPUTS     = N_INPUTS_DEFAULT,
    parameter int TICK_CYCLES  = TICK_CYCLES_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic [N_INPUTS-1:0]         in,
    output logic [N_INPUTS-1:0]         level,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [$clog2(N_INPUTS)-1:0] ev_chan,
    output logic                        ev_press,
    output logic                        overflow,
`ifdef BUTTON_EVENT_CTRL_TIMESTAMP_EN
    output logic [STAMP_W-1:0]          ev_time,
`endif
    input  logic                        clear_overflow
);

    localparam int CW = $clog2(N_INPUTS);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] CNT_LAST  = SW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] CHAN_LAST = CW'(N_INPUTS - 1);

    logic [N_INPUTS-1:0] sync_a;
    logic [N_INPUTS-1:0] sync_b;
    logic [PW-1:0]       pre_cnt;
    logic                tick;
    logic [SW-1:0]       stab_cnt [N_INPUTS];
    logic [N_INPUTS-1:0] qual;
    logic [N_INPUTS-1:0] pend;
    logic [N_INPUTS-1:0] pend_dir;
    logic [N_INPUTS-1:0] grant;
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       arb_chan;
    logic [CW-1:0]       arb_sel;
    logic                arb_any;
    int                  arb_idx;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_ready;
    logic                push;
    logic                pop;
    logic                ovf_set;
    evt_t                push_evt;
    evt_t                head_evt;

`ifdef BUTTON_EVENT_CTRL_TIMESTAMP_EN
    logic [STAMP_W-1:0]  tick_time;
    logic [STAMP_W-1:0]  pend_stamp [N_INPUTS];
`endif

    // Two-flop synchronizer on every raw button line.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= in;
            sync_b <= sync_a;
        end
    end

    assign tick = (pre_cnt == TICK_LAST);

    // Shared prescaler producing the debounce tick.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // A channel qualifies on the tick that completes its stable run.
    always_comb begin
        qual = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            qual[i] = tick && (sync_b[i] != level[i])
                      && (stab_cnt[i] == CNT_LAST);
        end
    end

    // Per-channel stable-tick counters and debounced level.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            level <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (sync_b[i] == level[i]) begin
                    stab_cnt[i] <= '0;
                end else if (qual[i]) begin
                    stab_cnt[i] <= '0;
                    level[i]    <= ~level[i];
                end else if (tick) begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Round-robin search for the first pending channel from rr_ptr.
    always_comb begin
        arb_any  = 1'b0;
        arb_chan = '0;
        arb_sel  = '0;
        arb_idx  = 0;
        for (int off = 0; off < N_INPUTS; off++) begin
            arb_idx = int'(rr_ptr) + off;
            if (arb_idx >= N_INPUTS) begin
                arb_idx = arb_idx - N_INPUTS;
            end
            arb_sel = CW'(arb_idx);
            if (!arb_any && pend[arb_sel]) begin
                arb_any  = 1'b1;
                arb_chan = arb_sel;
            end
        end
    end

    assign pop        = !fifo_empty && ev_ready;
    assign fifo_ready = !fifo_full || pop;
    assign push       = arb_any && fifo_ready;

    // One-hot grant and the record written into the queue.
    always_comb begin
        grant          = '0;
        push_evt       = '0;
        push_evt.chan  = CHAN_W'(arb_chan);
        push_evt.press = pend_dir[arb_chan];
`ifdef BUTTON_EVENT_CTRL_TIMESTAMP_EN
        push_evt.stamp = pend_stamp[arb_chan];
`endif
        if (push) begin
            grant[arb_chan] = 1'b1;
        end
    end

    // Requalifying while still pending collapses press+release.
    assign ovf_set = |(qual & pend & ~grant);

    // Pending flags, their direction and the arbiter pointer.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            pend     <= '0;
            pend_dir <= '0;
            rr_ptr   <= '0;
        end else begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (qual[i]) begin
                    if (pend[i] && !grant[i]) begin
                        pend[i] <= 1'b0;
                    end else begin
                        pend[i]     <= 1'b1;
                        pend_dir[i] <= ~level[i];
                    end
                end else if (grant[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            if (push) begin
                rr_ptr <= (arb_chan == CHAN_LAST) ? '0
                                                  : arb_chan + 1'b1;
            end
        end
    end

    // Sticky overflow; a new set outranks a same-cycle clear.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef BUTTON_EVENT_CTRL_TIMESTAMP_EN
    // Free-running tick count, wrapping naturally at 16 bits.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            tick_time <= '0;
        end else if (tick) begin
            tick_time <= tick_time + 1'b1;
        end
    end

    // Stamp captured when the channel qualifies.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                pend_stamp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (qual[i]) begin
                    pend_stamp[i] <= tick_time;
                end
            end
        end
    end

    assign ev_time = head_evt.stamp;
`endif

    evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk  (aclk),
        .reset (reset),
        .push  (push),
        .data  (push_evt),
        .full  (fifo_full),
        .pop   (pop),
        .head  (head_evt),
        .empty (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign ev_chan  = CW'(head_evt.chan);
    assign ev_press = head_evt.press;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: vector table, directed corner sequences
// and random button activity against a tick-arithmetic reference model.
module tb_button_event_ctrl;

    localparam int N  = 4;
    localparam int TC = 4;
    localparam int ST = 3;
    localparam int FD = 4;

    logic       aclk = 1'b0;
    logic       reset;
    logic [3:0] in_v;
    logic [3:0] level;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_chan;
    logic       ev_press;
    logic       overflow;
    logic       clear_overflow;

    always #5 aclk = ~aclk;

    button_event_ctrl #(
        .N_INPUTS     (N),
        .TICK_CYCLES  (TC),
        .STABLE_TICKS (ST),
        .FIFO_DEPTH   (FD)
    ) dut (
        .aclk           (aclk),
        .reset          (reset),
        .in             (in_v),
        .level          (level),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_chan        (ev_chan),
        .ev_press       (ev_press),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int chan;
        int press;
        int cyc;
    } ev_rec_t;

    ev_rec_t got [$];

    always @(posedge aclk) cyc <= cyc + 1;

    // Record every completed handshake.
    always @(posedge aclk) begin
        if (!reset && ev_valid && ev_ready) begin
            got.push_back('{int'(ev_chan), int'(ev_press), cyc});
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int got_chan(int j);
        return (j < got.size()) ? got[j].chan : -1;
    endfunction

    function automatic int got_press(int j);
        return (j < got.size()) ? got[j].press : -1;
    endfunction

    function automatic int got_cyc(int j);
        return (j < got.size()) ? got[j].cyc : -1;
    endfunction

    // Reference model: edge index k counts clock edges since reset
    // release; ticks fall on edges with k % TC == TC-1. The synchronized
    // value seen at edge k is the input applied at edge k-2. A channel
    // flips when the ticks inside its disagreement window reach ST.
    int         m_k;
    logic [3:0] m_in1;
    logic [3:0] m_in2;
    logic [3:0] m_lvl;
    int         m_d [4];
    int         exp_q [4][$];

    function automatic int ticks_upto(int k);
        return (k + 1) / TC;
    endfunction

    task automatic model_edge(input logic [3:0] v);
        for (int c = 0; c < 4; c++) begin
            if (m_in2[c] == m_lvl[c]) begin
                m_d[c] = -1;
            end else begin
                if (m_d[c] < 0) m_d[c] = m_k;
                if ((m_k % TC == TC - 1) &&
                    (ticks_upto(m_k) - m_d[c] / TC == ST)) begin
                    m_lvl[c] = ~m_lvl[c];
                    exp_q[c].push_back(int'(m_lvl[c]));
                    m_d[c] = -1;
                end
            end
        end
        m_in2 = m_in1;
        m_in1 = v;
        m_k++;
    endtask

    task automatic step();
        @(posedge aclk);
        model_edge(in_v);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] v);
        reset          = 1'b1;
        in_v           = v;
        ev_ready       = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        reset = 1'b0;
        m_k   = 0;
        m_in1 = '0;
        m_in2 = '0;
        m_lvl = '0;
        for (int c = 0; c < 4; c++) begin
            m_d[c] = -1;
            exp_q[c].delete();
        end
        got.delete();
    endtask

    typedef struct {
        logic [3:0] in;
        int         hold;
        logic [3:0] lvl;
        int         nev;
        int         chan;
        int         press;
    } vec_t;

    vec_t tbl [7];

    int hold_c [4];
    int exp_ch [6];
    int exp_pr [6];
    int c_ev;

    initial begin
        tbl[0] = '{4'b0001, 20, 4'b0001, 1,  0,  1};
        tbl[1] = '{4'b0011,  8, 4'b0001, 0, -1, -1};
        tbl[2] = '{4'b0001, 20, 4'b0001, 0, -1, -1};
        tbl[3] = '{4'b0000, 20, 4'b0000, 1,  0,  0};
        tbl[4] = '{4'b0100,  4, 4'b0000, 0, -1, -1};
        tbl[5] = '{4'b1000, 20, 4'b1000, 1,  3,  1};
        tbl[6] = '{4'b0000, 20, 4'b0000, 1,  3,  0};

        // Reset values and exact qualification / handshake timing.
        reset          = 1'b1;
        in_v           = '0;
        ev_ready       = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_chan", ev_chan, 0);
        chk("rst_ev_press", ev_press, 0);
        chk("rst_overflow", overflow, 0);
        do_reset(4'b0001);
        repeat (11) step();
        chk("a_level_before_3rd_tick", level, 0);
        step();
        chk("a_level_at_3rd_tick", level, 1);
        chk("a_valid_same_cycle_as_pend", ev_valid, 0);
        step();
        chk("a_valid_after_push", ev_valid, 1);
        chk("a_chan", ev_chan, 0);
        chk("a_press", ev_press, 1);
        repeat (2) step();
        chk("a_hold_valid", ev_valid, 1);
        chk("a_hold_chan", ev_chan, 0);
        chk("a_hold_press", ev_press, 1);
        ev_ready = 1'b1;
        step();
        chk("a_popped", ev_valid, 0);
        chk("a_one_event", got.size(), 1);

        // Vector table: held changes qualify, short glitches do not.
        do_reset(4'b0000);
        ev_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            got.delete();
            in_v = tbl[i].in;
            repeat (tbl[i].hold) step();
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("tbl%0d_nev", i), got.size(), tbl[i].nev);
            chk($sformatf("tbl%0d_chan", i), got_chan(0), tbl[i].chan);
            chk($sformatf("tbl%0d_press", i), got_press(0), tbl[i].press);
        end

        // All four rise together: delivered 0..3 on consecutive cycles.
        do_reset(4'b1111);
        ev_ready = 1'b1;
        repeat (20) step();
        chk("b_count", got.size(), 4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("b_chan%0d", j), got_chan(j), j);
            chk($sformatf("b_cyc%0d", j), got_cyc(j) - got_cyc(0), j);
        end

        // Six events with the consumer stalled: four queued, two pending.
        do_reset(4'b1111);
        repeat (20) step();
        in_v = 4'b1100;
        repeat (20) step();
        chk("c_level_while_full", level, 4'b1100);
        chk("c_valid", ev_valid, 1);
        chk("c_none_taken", got.size(), 0);
        ev_ready = 1'b1;
        repeat (12) step();
        exp_ch = '{0, 1, 2, 3, 0, 1};
        exp_pr = '{1, 1, 1, 1, 0, 0};
        chk("c_count", got.size(), 6);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("c_chan%0d", j), got_chan(j), exp_ch[j]);
            chk($sformatf("c_press%0d", j), got_press(j), exp_pr[j]);
        end
        chk("c_overflow", overflow, 0);

        // Press then release on ch2 while full collapses to nothing.
        do_reset(4'b1011);
        repeat (20) step();
        in_v = 4'b0011;
        repeat (20) step();
        in_v = 4'b0111;
        repeat (20) step();
        chk("d_ovf_before", overflow, 0);
        in_v = 4'b0011;
        repeat (20) step();
        chk("d_ovf_set", overflow, 1);
        chk("d_level", level, 4'b0011);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        chk("d_ovf_cleared", overflow, 0);
        ev_ready = 1'b1;
        repeat (12) step();
        exp_ch = '{0, 1, 3, 3, -1, -1};
        exp_pr = '{1, 1, 1, 0, -1, -1};
        chk("d_count", got.size(), 4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("d_chan%0d", j), got_chan(j), exp_ch[j]);
            chk($sformatf("d_press%0d", j), got_press(j), exp_pr[j]);
        end

        // Reset with three queued events discards them.
        do_reset(4'b0111);
        repeat (20) step();
        chk("e_queued", ev_valid, 1);
        chk("e_level", level, 4'b0111);
        reset = 1'b1;
        #1;
        chk("e_rst_valid", ev_valid, 0);
        chk("e_rst_level", level, 0);
        chk("e_rst_ovf", overflow, 0);
        do_reset(4'b0111);
        ev_ready = 1'b1;
        repeat (20) step();
        chk("e_count", got.size(), 3);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("e_chan%0d", j), got_chan(j), j);
            chk($sformatf("e_press%0d", j), got_press(j), 1);
        end

        // Random button activity against the reference model.
        do_reset(4'b0000);
        ev_ready = 1'b1;
        for (int c = 0; c < 4; c++) hold_c[c] = $urandom_range(1, 30);
        for (int t = 0; t < 2500; t++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold_c[c] == 0) begin
                    in_v[c]   = ~in_v[c];
                    hold_c[c] = $urandom_range(1, 30);
                end else begin
                    hold_c[c]--;
                end
            end
            step();
            chk("r_level", level, m_lvl);
        end
        repeat (60) step();
        chk("r_level_final", level, m_lvl);
        c_ev = 0;
        for (int c = 0; c < 4; c++) c_ev += exp_q[c].size();
        chk("r_total", got.size(), c_ev);
        for (int j = 0; j < got.size(); j++) begin
            if (exp_q[got[j].chan].size() == 0) begin
                chk($sformatf("r_extra_ch%0d", got[j].chan), 1, 0);
            end else begin
                chk($sformatf("r_press_ch%0d", got[j].chan),
                    got[j].press, exp_q[got[j].chan].pop_front());
            end
        end
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("r_left_ch%0d", c), exp_q[c].size(), 0);
        end
        chk("r_overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
